// File: rtl/four_led_pkg.sv
// Shared state type and LED decode for the rotating four-LED sequencer.
package four_led_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } state_t;

  // LED vector is {led0, led1, led2, led3}; led0 is the MSB.
  function automatic logic [3:0] led_decode(input state_t s);
    logic [3:0] v;
    case (s)
      S0:      v = 4'b1000;
      S1:      v = 4'b0100;
      S2:      v = 4'b0010;
      S3:      v = 4'b0001;
      default: v = 4'b1000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/four_led_tick.sv
// Prescaler: pulses tick once every TICK_DIV clock cycles.
module four_led_tick #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic resetBtn,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  // With TICK_DIV=1 LAST is 0, so the counter never leaves 0 and tick stays high.
  logic [CW-1:0] cnt = '0;

  always_ff @(posedge clk) begin
    if (resetBtn || (cnt == LAST)) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

  always_comb begin
    tick = (cnt == LAST);
  end

endmodule

// File: rtl/four_led_fsm.sv
// Moore sequencer rotating a single lit LED led0 -> led1 -> led2 -> led3.
module four_led_fsm
  import four_led_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic clk,
  input  logic resetBtn,
  output logic led0,
  output logic led1,
  output logic led2,
  output logic led3
);

  logic   tick;
  // Power-up value keeps the outputs one-hot before the first reset.
  state_t state = S0;
  state_t state_nxt;

  four_led_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .resetBtn (resetBtn),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (resetBtn) state <= S0;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      case (state)
        S0:      state_nxt = S1;
        S1:      state_nxt = S2;
        S2:      state_nxt = S3;
        S3:      state_nxt = S0;
        default: state_nxt = S0;
      endcase
    end
  end

  always_comb begin
    {led0, led1, led2, led3} = led_decode(state);
  end

endmodule

// File: tb/tb_four_led_fsm.sv
// Randomized self-checking bench for four_led_fsm at TICK_DIV=1 and TICK_DIV=3.
module tb_four_led_fsm;

  logic       clk = 1'b0;
  logic       resetBtn = 1'b1;
  logic [3:0] led_a;
  logic [3:0] led_b;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned k_a = 0;
  int unsigned k_b = 0;

  always #5 clk = ~clk;

  four_led_fsm #(.TICK_DIV(1)) dut_a (
    .clk(clk), .resetBtn(resetBtn),
    .led0(led_a[3]), .led1(led_a[2]), .led2(led_a[1]), .led3(led_a[0])
  );

  four_led_fsm #(.TICK_DIV(3)) dut_b (
    .clk(clk), .resetBtn(resetBtn),
    .led0(led_b[3]), .led1(led_b[2]), .led2(led_b[1]), .led3(led_b[0])
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: k edges since reset release; position = (k / div) mod 4.
  function automatic logic [3:0] model_led(input int unsigned k, input int unsigned div);
    logic [3:0] base;
    base = 4'b1000;
    return base >> ((k / div) % 4);
  endfunction

  task automatic step(input logic r);
    resetBtn = r;
    @(posedge clk);
    if (r) begin k_a = 0; k_b = 0; end
    else   begin k_a++;   k_b++;   end
    #1;
    check("div1_led", led_a, model_led(k_a, 1));
    check("div3_led", led_b, model_led(k_b, 3));
    check("div1_onehot", 4'($countones(led_a)), 4'd1);
    check("div3_onehot", 4'($countones(led_b)), 4'd1);
  endtask

  initial begin
    #1;
    // reset held for two edges
    step(1'b1);
    step(1'b1);

    // rotation, TICK_DIV=1 over 8 edges (also covers TICK_DIV=3 prescaled steps)
    for (int i = 0; i < 8; i++) step(1'b0);

    // mid-sequence reset from S2
    step(1'b1);
    step(1'b0);
    step(1'b0);
    check("div1_at_s2", led_a, 4'b0010);
    step(1'b1);
    check("div1_midreset", led_a, 4'b1000);
    step(1'b0);
    check("div1_after_release", led_a, 4'b0100);

    // prescaler, TICK_DIV=3: 12 edges after release
    step(1'b1);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0);
      if (i == 2)  check("div3_edge2", led_b, 4'b1000);
      if (i == 3)  check("div3_edge3", led_b, 4'b0100);
      if (i == 6)  check("div3_edge6", led_b, 4'b0010);
      if (i == 12) check("div3_edge12", led_b, 4'b1000);
    end

    // reset on the counter-wrap edge of TICK_DIV=3
    step(1'b1);
    step(1'b0);
    step(1'b0);
    step(1'b1);
    check("div3_wrap_reset", led_b, 4'b1000);
    step(1'b0);
    step(1'b0);
    check("div3_wrap_hold", led_b, 4'b1000);
    step(1'b0);
    check("div3_wrap_adv", led_b, 4'b0100);

    // random reset pulses
    for (int i = 0; i < 1000; i++) step(($urandom % 16) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
